// File: rtl/bin_to_rns_9_8_7.sv
// Serial MSB-first binary to RNS (9,8,7) converter, one bit per clock.
// Optional operand range check: define BIN2RNS_RANGE_CHECK_EN.
module bin_to_rns_9_8_7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] x1,
  output logic [2:0] x2,
  output logic [2:0] x3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t     state;
  logic [8:0] sr;
  logic [3:0] cnt;
  logic [3:0] r9;
  logic [2:0] r8;
  logic [2:0] r7;

  logic       b;
  logic [4:0] t9;
  logic [4:0] d9;
  logic [3:0] n9;
  logic [3:0] t7;
  logic [3:0] d7;
  logic [2:0] n7;

  // Next residues: double, add the incoming bit, fold back once.
  always_comb begin
    b  = sr[8];
    t9 = {r9, b};
    d9 = t9 - 5'd9;
    n9 = (t9 >= 5'd9) ? d9[3:0] : t9[3:0];
    t7 = {r7, b};
    d7 = t7 - 4'd7;
    n7 = (t7 >= 4'd7) ? d7[2:0] : t7[2:0];
  end

  // Control FSM plus shift register, bit counter and residue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      r9    <= '0;
      r8    <= '0;
      r7    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= in_data;
            cnt   <= '0;
            r9    <= '0;
            r8    <= '0;
            r7    <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= {sr[7:0], 1'b0};
          r9  <= n9;
          r8  <= {r8[1:0], b};
          r7  <= n7;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign x1        = r9;
  assign x2        = r8;
  assign x3        = r7;

`ifdef BIN2RNS_RANGE_CHECK_EN
  logic err_q;

  // Flag out-of-range operands at accept; drop the flag on output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      err_q <= (in_data >= 9'd504);
    end else if (state == DONE && out_ready) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_rns_9_8_7.sv
// Randomized and directed bench for bin_to_rns_9_8_7.
// Expected residues come from plain modulo arithmetic.
module tb_bin_to_rns_9_8_7;

  logic       clk;
  logic       rst_n;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x1;
  logic [2:0] x2;
  logic [2:0] x3;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  int total;
  int bad;

  bin_to_rns_9_8_7 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_err(input int v);
`ifdef BIN2RNS_RANGE_CHECK_EN
    return (v >= 504) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Called at posedge+1; converts v, stalls the output, then transfers it.
  task automatic do_conv(input int v, input int stall, input bit poke);
    int n;
    int e9, e8, e7;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rdy_wait", in_ready, 1);
    e9 = (v % 504) % 9;
    e8 = (v % 504) % 8;
    e7 = (v % 504) % 7;
    in_data  = 9'(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 9);
    chk("x1", x1, e9);
    chk("x2", x2, e8);
    chk("x3", x3, e7);
    chk("err", err, exp_err(v));
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_data  = 9'(v ^ 9'h155);
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      chk("hold_x1", x1, e9);
      chk("hold_x2", x2, e8);
      chk("hold_x3", x3, e7);
      chk("hold_ov", out_valid, 1);
      chk("hold_ir", in_ready, 0);
      chk("hold_err", err, exp_err(v));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("xfer_ov", out_valid, 0);
    chk("xfer_ir", in_ready, 1);
    chk("xfer_err", err, 0);
  endtask

  // Back-to-back conversions of 0..503 with out_ready tied high.
  task automatic sweep();
    int q[$];
    int v, got, last, cyc, e;
    bit acc;
    v = 0;
    got = 0;
    last = -1;
    cyc = 0;
    acc = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_valid  = 1'b1;
    while (got < 504 && cyc < 6000) begin
      if (acc) begin
        v++;
        acc = 1'b0;
        if (v > 503) in_valid = 1'b0;
        else in_data = 9'(v);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("sweep_q", 0, 1);
        end else begin
          e = q.pop_front();
          chk("sw_x1", x1, e % 9);
          chk("sw_x2", x2, e % 8);
          chk("sw_x3", x3, e % 7);
        end
        if (last >= 0) chk("sw_gap", cyc - last, 11);
        last = cyc;
        got++;
      end
      if (in_ready && in_valid) begin
        q.push_back(v);
        acc = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("sweep_cnt", got, 504);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x1", x1, 0);
    chk("rst_x2", x2, 0);
    chk("rst_x3", x3, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_conv(0, 0, 1'b0);
    do_conv(503, 0, 1'b0);
    do_conv(100, 1, 1'b0);
    do_conv(255, 5, 1'b1);
    do_conv(505, 2, 1'b0);
    do_conv(7, 0, 1'b0);

    // Reset during the fourth shift cycle of 300.
    in_data  = 9'd300;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_x1", x1, 0);
    chk("mid_x2", x2, 0);
    chk("mid_x3", x3, 0);
    chk("mid_ir", in_ready, 1);
    chk("mid_ov", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("no_ov_after_rst", n, 0);
    do_conv(300, 0, 1'b0);

    sweep();

    for (int i = 0; i < 40; i++) begin
      do_conv(int'($urandom_range(0, 511)),
              int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
